// File: rtl/qam_pkg.sv
// == qam_pkg : shared types and defaults for the 16-QAM symbol sequencer ==
// == rev 1.0                                                              ==
`default_nettype none

package qam_pkg;

  typedef logic [3:0] sym_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    DRAIN    = 2'd3
  } seq_state_t;

  localparam sym_t DEF_PRE_A    = 4'hF;
  localparam sym_t DEF_PRE_B    = 4'h0;
  localparam sym_t DEF_IDLE_SYM = 4'h0;

  // Upper two bits drive the I amplitude, lower two the Q amplitude.
  function automatic logic [1:0] sym_i_bits(input sym_t s);
    return s[3:2];
  endfunction

  function automatic logic [1:0] sym_q_bits(input sym_t s);
    return s[1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/qam_sym_fifo.sv
// == qam_sym_fifo : synchronous symbol FIFO, registered occupancy count ==
// == rev 1.0                                                            ==
`default_nettype none

module qam_sym_fifo
  import qam_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  sym_t                     din,
  output sym_t                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  sym_t            mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [LW-1:0]   level_q;
  logic            w_do_push;
  logic            w_do_pop;

  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(DEPTH));
  assign level = level_q;
  assign dout  = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the same cycle pops a slot free.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (w_do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (w_do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (w_do_push && !w_do_pop) begin
        level_q <= level_q + LW'(1);
      end else if (!w_do_push && w_do_pop) begin
        level_q <= level_q - LW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/qam_symbol_sequencer.sv
// == qam_symbol_sequencer : bit assembly, preamble/data/drain sequencing ==
// == and carrier phase generation for the 16-QAM modulator.  rev 1.0     ==
`default_nettype none

module qam_symbol_sequencer
  import qam_pkg::*;
#(
  parameter int   SPS          = 16,
  parameter int   PHASE_W      = 4,
  parameter int   FIFO_DEPTH   = 4,
  parameter int   PREAMBLE_LEN = 4,
  parameter sym_t PRE_A        = DEF_PRE_A,
  parameter sym_t PRE_B        = DEF_PRE_B,
  parameter sym_t IDLE_SYM     = DEF_IDLE_SYM
) (
  input  logic                          clk_16,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          bit_in,
  input  logic                          bit_valid,
  output logic [1:0]                    bitsa,
  output logic [1:0]                    bitsb,
  output logic [PHASE_W-1:0]            carrier_phase,
  output logic                          sym_strobe,
  output logic                          tx_active,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic                          overflow
);

  localparam int CNT_W  = $clog2(SPS);
  localparam int SLOT_W = $clog2(PREAMBLE_LEN + 1);

  seq_state_t          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  sym_t                cur_sym_q, cur_sym_d;
  logic                strobe_q, strobe_d;
  logic                active_q, active_d;
  logic                underrun_q, underrun_d;
  logic                overflow_q, overflow_d;
  logic [2:0]          shreg_q, shreg_d;
  logic [1:0]          bitcnt_q, bitcnt_d;

  logic                w_boundary;
  logic                w_next_sym;
  logic                w_to_idle;
  logic                w_accept;
  logic                w_push;
  logic                w_pop;
  sym_t                w_fifo_dout;
  logic                w_fifo_full;
  logic                w_fifo_empty;

  assign w_boundary = active_q && (cnt_q == CNT_W'(SPS - 1));
  assign w_accept   = bit_valid && enable && !rst;

  qam_sym_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_16),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   ({shreg_q, bit_in}),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    slot_d     = slot_q;
    phase_d    = phase_q;
    cur_sym_d  = cur_sym_q;
    strobe_d   = 1'b0;
    active_d   = active_q;
    underrun_d = underrun_q;
    w_next_sym = 1'b0;
    w_to_idle  = 1'b0;
    w_pop      = 1'b0;

    if (active_q) begin
      cnt_d   = w_boundary ? '0 : cnt_q + CNT_W'(1);
      phase_d = phase_q + PHASE_W'(1);
    end

    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        slot_d    = '0;
        phase_d   = '0;
        cur_sym_d = '0;
        if (enable) begin
          state_d   = PREAMBLE;
          active_d  = 1'b1;
          cur_sym_d = PRE_A;
          strobe_d  = 1'b1;
        end
      end
      PREAMBLE: begin
        // enable is only consulted once the last preamble slot has ended.
        if (w_boundary) begin
          if (slot_q == SLOT_W'(PREAMBLE_LEN - 1)) begin
            w_next_sym = 1'b1;
          end else begin
            slot_d    = slot_q + SLOT_W'(1);
            cur_sym_d = slot_q[0] ? PRE_A : PRE_B;
            strobe_d  = 1'b1;
          end
        end
      end
      DATA, DRAIN: begin
        state_d    = enable ? DATA : DRAIN;
        w_next_sym = w_boundary;
      end
      default: state_d = IDLE;
    endcase

    // Symbol selection after the preamble: enable picks DATA or DRAIN rules.
    if (w_next_sym) begin
      strobe_d = 1'b1;
      if (!w_fifo_empty) begin
        w_pop     = 1'b1;
        cur_sym_d = w_fifo_dout;
        state_d   = enable ? DATA : DRAIN;
      end else if (enable) begin
        cur_sym_d  = IDLE_SYM;
        underrun_d = 1'b1;
        state_d    = DATA;
      end else begin
        state_d   = IDLE;
        w_to_idle = 1'b1;
        active_d  = 1'b0;
        strobe_d  = 1'b0;
        cur_sym_d = '0;
        cnt_d     = '0;
        phase_d   = '0;
      end
    end

    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    w_push   = 1'b0;
    if (w_to_idle) begin
      shreg_d  = '0;
      bitcnt_d = '0;
    end else if (w_accept) begin
      shreg_d  = {shreg_q[1:0], bit_in};
      bitcnt_d = bitcnt_q + 2'd1;
      w_push   = (bitcnt_q == 2'd3);
    end

    overflow_d = overflow_q | (w_push & w_fifo_full & ~w_pop);
  end

  always_ff @(posedge clk_16) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      slot_q     <= '0;
      phase_q    <= '0;
      cur_sym_q  <= '0;
      strobe_q   <= 1'b0;
      active_q   <= 1'b0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
      shreg_q    <= '0;
      bitcnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      slot_q     <= slot_d;
      phase_q    <= phase_d;
      cur_sym_q  <= cur_sym_d;
      strobe_q   <= strobe_d;
      active_q   <= active_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
      shreg_q    <= shreg_d;
      bitcnt_q   <= bitcnt_d;
    end
  end

  assign bitsa         = sym_i_bits(cur_sym_q);
  assign bitsb         = sym_q_bits(cur_sym_q);
  assign carrier_phase = phase_q;
  assign sym_strobe    = strobe_q;
  assign tx_active     = active_q;
  assign underrun      = underrun_q;
  assign overflow      = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_qam_symbol_sequencer.sv
// == tb_qam_symbol_sequencer : directed vector bench, SPS=4 main instance ==
// == plus an SPS=8 instance for the FIFO-full cases.  rev 1.0            ==
`default_nettype none

module tb_qam_symbol_sequencer;

  logic clk;
  logic rst;
  logic enable;
  logic bit_in;
  logic bit_valid;

  logic [1:0] a4, b4, a8, b8;
  logic [3:0] ph4, ph8;
  logic       stb4, act4, und4, ovf4, stb8, act8, und8, ovf8;
  logic [2:0] lvl4, lvl8;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst, en, bv, bi;
    logic [1:0] a, b;
    logic [3:0] ph;
    logic       stb, act;
    logic [2:0] lvl;
    logic       und, ovf;
  } vec_t;

  vec_t       tbl [26];
  logic [3:0] syms [6];
  logic [7:0] pat2;

  qam_symbol_sequencer #(.SPS(4), .PHASE_W(4), .FIFO_DEPTH(4), .PREAMBLE_LEN(4)) u_dut4 (
    .clk_16(clk), .rst(rst), .enable(enable), .bit_in(bit_in), .bit_valid(bit_valid),
    .bitsa(a4), .bitsb(b4), .carrier_phase(ph4), .sym_strobe(stb4), .tx_active(act4),
    .fifo_level(lvl4), .underrun(und4), .overflow(ovf4));

  // Longer symbol period so more than FIFO_DEPTH symbols fit in the preamble.
  qam_symbol_sequencer #(.SPS(8), .PHASE_W(4), .FIFO_DEPTH(4), .PREAMBLE_LEN(4)) u_dut8 (
    .clk_16(clk), .rst(rst), .enable(enable), .bit_in(bit_in), .bit_valid(bit_valid),
    .bitsa(a8), .bitsb(b8), .carrier_phase(ph8), .sym_strobe(stb8), .tx_active(act8),
    .fifo_level(lvl8), .underrun(und8), .overflow(ovf8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input int r, input int e, input int v, input int bi,
                              input int ea, input int eb, input int ep, input int es,
                              input int ec, input int el, input int eu, input int eo);
    vec_t m;
    m.rst = r[0];  m.en = e[0];   m.bv = v[0];    m.bi = bi[0];
    m.a = ea[1:0]; m.b = eb[1:0]; m.ph = ep[3:0]; m.stb = es[0];
    m.act = ec[0]; m.lvl = el[2:0]; m.und = eu[0]; m.ovf = eo[0];
    return m;
  endfunction

  function automatic logic sbit(input int n);
    logic [3:0] s;
    s = syms[n / 4];
    return s[3 - (n % 4)];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    logic [14:0] got, exp;
    syms[0] = 4'h1; syms[1] = 4'h6; syms[2] = 4'hA;
    syms[3] = 4'hD; syms[4] = 4'h7; syms[5] = 4'h9;
    pat2 = 8'b1011_0110;

    //             rst en bv bi  a  b  ph stb act lvl und ovf
    tbl[0]  = mk(1, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0,  3, 3,  0, 1, 1, 0, 0, 0);
    tbl[2]  = mk(0, 1, 0, 0,  3, 3,  1, 0, 1, 0, 0, 0);
    tbl[3]  = mk(0, 1, 0, 0,  3, 3,  2, 0, 1, 0, 0, 0);
    tbl[4]  = mk(0, 1, 0, 0,  3, 3,  3, 0, 1, 0, 0, 0);
    tbl[5]  = mk(0, 1, 0, 0,  0, 0,  4, 1, 1, 0, 0, 0);
    tbl[6]  = mk(0, 1, 0, 0,  0, 0,  5, 0, 1, 0, 0, 0);
    tbl[7]  = mk(0, 1, 0, 0,  0, 0,  6, 0, 1, 0, 0, 0);
    tbl[8]  = mk(0, 1, 0, 0,  0, 0,  7, 0, 1, 0, 0, 0);
    tbl[9]  = mk(0, 1, 0, 0,  3, 3,  8, 1, 1, 0, 0, 0);
    tbl[10] = mk(0, 1, 0, 0,  3, 3,  9, 0, 1, 0, 0, 0);
    tbl[11] = mk(0, 1, 0, 0,  3, 3, 10, 0, 1, 0, 0, 0);
    tbl[12] = mk(0, 1, 0, 0,  3, 3, 11, 0, 1, 0, 0, 0);
    tbl[13] = mk(0, 1, 0, 0,  0, 0, 12, 1, 1, 0, 0, 0);
    tbl[14] = mk(0, 1, 0, 0,  0, 0, 13, 0, 1, 0, 0, 0);
    tbl[15] = mk(0, 1, 0, 0,  0, 0, 14, 0, 1, 0, 0, 0);
    tbl[16] = mk(0, 1, 0, 0,  0, 0, 15, 0, 1, 0, 0, 0);
    tbl[17] = mk(0, 1, 0, 0,  0, 0,  0, 1, 1, 0, 1, 0);
    tbl[18] = mk(0, 1, 0, 0,  0, 0,  1, 0, 1, 0, 1, 0);
    tbl[19] = mk(0, 1, 0, 0,  0, 0,  2, 0, 1, 0, 1, 0);
    tbl[20] = mk(0, 1, 0, 0,  0, 0,  3, 0, 1, 0, 1, 0);
    tbl[21] = mk(0, 1, 0, 0,  0, 0,  4, 1, 1, 0, 1, 0);
    tbl[22] = mk(0, 0, 0, 0,  0, 0,  5, 0, 1, 0, 1, 0);
    tbl[23] = mk(0, 0, 0, 0,  0, 0,  6, 0, 1, 0, 1, 0);
    tbl[24] = mk(0, 0, 0, 0,  0, 0,  7, 0, 1, 0, 1, 0);
    tbl[25] = mk(0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 1, 0);

    // Preamble, underrun padding, drain to idle with an empty FIFO.
    for (int i = 0; i < 26; i++) begin
      rst = tbl[i].rst; enable = tbl[i].en; bit_valid = tbl[i].bv; bit_in = tbl[i].bi;
      cyc();
      got = {a4, b4, ph4, stb4, act4, lvl4, und4, ovf4};
      exp = {tbl[i].a, tbl[i].b, tbl[i].ph, tbl[i].stb, tbl[i].act, tbl[i].lvl,
             tbl[i].und, tbl[i].ovf};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL tbl[%0d] got %b expected %b", i, got, exp);
      end
    end

    // Two symbols during the preamble, enable dropped: drain B then 6.
    do_reset();
    for (int v = 1; v <= 25; v++) begin
      enable = (v <= 8); bit_valid = (v <= 8); bit_in = (v <= 8) ? pat2[8 - v] : 1'b0;
      cyc();
      case (v)
        8:  chk("drain_lvl_after_bits", 32'(lvl4), 2);
        17: chk("drain_symB", 32'({a4, b4, stb4, lvl4}), 32'({2'd2, 2'd3, 1'b1, 3'd1}));
        21: chk("drain_sym6", 32'({a4, b4, stb4, lvl4}), 32'({2'd1, 2'd2, 1'b1, 3'd0}));
        25: chk("drain_idle", 32'({act4, a4, b4, ph4, stb4, und4}), 0);
        default: ;
      endcase
    end

    // Six symbols into a depth-4 FIFO before the first pop: two dropped.
    do_reset();
    for (int v = 1; v <= 65; v++) begin
      enable = 1'b1; bit_valid = (v <= 24); bit_in = (v <= 24) ? sbit(v - 1) : 1'b0;
      cyc();
      case (v)
        24: chk("ovf_full", 32'({lvl8, ovf8, act8}), 32'({3'd4, 1'b1, 1'b1}));
        33: chk("ovf_sym0", 32'({a8, b8, lvl8}), 32'({2'd0, 2'd1, 3'd3}));
        41: chk("ovf_sym1", 32'({a8, b8, lvl8}), 32'({2'd1, 2'd2, 3'd2}));
        49: chk("ovf_sym2", 32'({a8, b8, lvl8}), 32'({2'd2, 2'd2, 3'd1}));
        57: chk("ovf_sym3", 32'({a8, b8, lvl8}), 32'({2'd3, 2'd1, 3'd0}));
        65: chk("ovf_then_idle", 32'({a8, b8, und8, ovf8}), 32'({2'd0, 2'd0, 1'b1, 1'b1}));
        default: ;
      endcase
    end

    // Push completing exactly at the first data boundary while full.
    do_reset();
    for (int v = 1; v <= 41; v++) begin
      enable = 1'b1; bit_valid = (v >= 14 && v <= 33);
      bit_in = (v >= 14 && v <= 33) ? sbit(v - 14) : 1'b0;
      cyc();
      case (v)
        32: chk("pp_pre_full", 32'({lvl8, ovf8}), 32'({3'd4, 1'b0}));
        33: chk("pp_same_cycle", 32'({a8, b8, stb8, lvl8, ovf8}),
                32'({2'd0, 2'd1, 1'b1, 3'd4, 1'b0}));
        41: chk("pp_next", 32'({a8, b8, lvl8, ovf8}), 32'({2'd1, 2'd2, 3'd3, 1'b0}));
        default: ;
      endcase
    end

    // Reset in DATA with three symbols buffered, then restart.
    do_reset();
    for (int v = 1; v <= 20; v++) begin
      enable = 1'b1; bit_valid = (v <= 16); bit_in = (v <= 16) ? sbit(v - 1) : 1'b0;
      rst = (v == 19);
      cyc();
      case (v)
        18: chk("rst_pre", 32'({a4, b4, lvl4, act4}), 32'({2'd0, 2'd1, 3'd3, 1'b1}));
        19: chk("rst_all_zero", 32'({a4, b4, ph4, stb4, act4, lvl4, und4, ovf4}), 0);
        20: chk("rst_restart", 32'({a4, b4, ph4, stb4, act4, lvl4}),
                32'({2'd3, 2'd3, 4'd0, 1'b1, 1'b1, 3'd0}));
        default: ;
      endcase
    end

    // Re-enable in DRAIN with two symbols left: no preamble, contiguous output.
    do_reset();
    for (int v = 1; v <= 33; v++) begin
      enable = !(v >= 18 && v <= 21); bit_valid = (v <= 16);
      bit_in = (v <= 16) ? sbit(v - 1) : 1'b0;
      cyc();
      case (v)
        17: chk("re_sym0", 32'({a4, b4, stb4, lvl4}), 32'({2'd0, 2'd1, 1'b1, 3'd3}));
        21: chk("re_drain_pop", 32'({a4, b4, stb4, lvl4}), 32'({2'd1, 2'd2, 1'b1, 3'd2}));
        22: chk("re_no_preamble", 32'({a4, b4, stb4, act4, lvl4}),
                32'({2'd1, 2'd2, 1'b0, 1'b1, 3'd2}));
        23, 24: chk("re_no_strobe", 32'(stb4), 0);
        25: chk("re_sym2", 32'({a4, b4, stb4, lvl4}), 32'({2'd2, 2'd2, 1'b1, 3'd1}));
        29: chk("re_sym3", 32'({a4, b4, stb4, lvl4}), 32'({2'd3, 2'd1, 1'b1, 3'd0}));
        33: chk("re_underrun", 32'({a4, b4, stb4, act4, und4}),
                32'({2'd0, 2'd0, 1'b1, 1'b1, 1'b1}));
        default: ;
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/qam_symbol_sequencer.md
Name: qam_symbol_sequencer

Overview:
- Sequences the 16-QAM modulator datapath (qamtheta).
- Assembles the serial input bit stream into 4-bit symbols and buffers them in a small FIFO.
- Presents each symbol to the modulator's bitsa/bitsb inputs for exactly SPS carrier samples, and drives the carrier phase index for the cos/sin lookup.
- Inserts a fixed preamble at burst start, pads underruns with an idle symbol, and drains the buffer cleanly when transmission is disabled.

Parameters:
- SPS, 16: clk_16 cycles per symbol (≥2).
- PHASE_W, 4: carrier_phase width; phase wraps modulo 2^PHASE_W.
- FIFO_DEPTH, 4: symbol FIFO depth (power of 2).
- PREAMBLE_LEN, 4: preamble symbols per burst (≥1).
- PRE_A, 4'hF: preamble symbol on even preamble slots.
- PRE_B, 4'h0: preamble symbol on odd preamble slots.
- IDLE_SYM, 4'h0: symbol emitted on FIFO underrun.

Ports:
- clk_16 input 1: system/sample clock.
- rst input 1: synchronous, active-high reset.
- enable input 1: transmit request.
- bit_in input 1: serial data bit.
- bit_valid input 1: bit_in qualifier, one bit per cycle max.
- bitsa output 2: I amplitude code to modulator.
- bitsb output 2: Q amplitude code to modulator.
- carrier_phase output PHASE_W: cos/sin sample index.
- sym_strobe output 1: one-cycle pulse on the first cycle of each new symbol.
- tx_active output 1: high while a symbol is being emitted.
- fifo_level output $clog2(FIFO_DEPTH)+1: symbols buffered.
- underrun output 1: sticky, idle symbol was inserted.
- overflow output 1: sticky, assembled symbol was dropped.

Behaviour:
- Reset (synchronous, active-high) values:
  - All outputs 0; state IDLE.
  - FIFO empty; bit counter 0; symbol counter 0.
  - Reset mid-burst aborts immediately; buffered data is discarded.
- Bit assembly:
  - A bit is accepted when bit_valid && enable && !rst.
  - Bits are taken MSB-first into a 4-bit symbol in this order: bitsa[1], bitsa[0], bitsb[1], bitsb[0].
  - The 4th accepted bit pushes the symbol into the FIFO in the same cycle.
  - Push while FIFO full and no pop that cycle: the symbol is dropped and overflow is set.
  - Push and pop in the same cycle while full: both succeed.
  - A partial symbol is cleared on entry to IDLE.
- FIFO:
  - Pop occurs only at a DATA/DRAIN symbol boundary.
  - A pop reads the pre-cycle contents; there is no push-to-pop bypass. Empty plus a simultaneous push/pop is an underrun.
- Symbol timer:
  - cnt runs 0..SPS-1 while tx_active.
  - A boundary is the cycle where cnt==SPS-1. At a boundary, the next symbol is registered onto bitsa/bitsb, cnt goes to 0, and sym_strobe=1 next cycle.
- carrier_phase:
  - Increments by 1 every cycle while tx_active, wrapping at 2^PHASE_W.
  - Forced to 0 in IDLE.
- State machine:
  - IDLE → PREAMBLE when enable=1. The next cycle has tx_active=1, bits=PRE_A, sym_strobe=1, cnt=0, phase=0.
  - PREAMBLE: preamble slot k emits PRE_A for even k, PRE_B for odd k. After slot PREAMBLE_LEN-1, at its boundary, go to DATA and pop the first data symbol (or IDLE_SYM with underrun).
  - DATA: at each boundary, pop if the FIFO is non-empty; otherwise emit IDLE_SYM and set underrun. enable=0 → DRAIN, with no change to the current symbol.
  - DRAIN: at a boundary, pop if non-empty. If empty, go to IDLE: tx_active=0, bits=0, phase=0, no strobe, underrun not set. enable=1 in DRAIN → DATA immediately, without a new preamble.
  - enable dropping during PREAMBLE: finish the preamble, then follow DRAIN rules.
- Latency:
  - enable → first preamble symbol on outputs: 1 cycle.
  - Last bit of a symbol → FIFO: same cycle. FIFO → output: at the next boundary.
- fifo_level reflects the post-update occupancy each cycle.

Decomposition:
- Package qam_pkg:
  - sym_t (4-bit), with field helpers for I and Q.
  - seq_state_t enum: IDLE, PREAMBLE, DATA, DRAIN.
  - Default PRE_A, PRE_B, IDLE_SYM constants.
- Sub-module qam_sym_fifo:
  - Synchronous FIFO parameterised by depth.
  - Ports: push, pop, din, dout, full, empty, level.
- FSM, bit assembler and timers live in the top module.

Test Plan (SPS=4, PREAMBLE_LEN=4, FIFO_DEPTH=4):
- Reset, then enable=1 with no bits:
  - Outputs show F,0,F,0 for 4 cycles each, with sym_strobe every 4 cycles.
  - Then IDLE_SYM 0 and underrun=1.
  - carrier_phase counts 0..15 and wraps.
- Bits 1,0,1,1,0,1,1,0 during the preamble, then enable=0:
  - Symbol B is emitted (bitsa=2, bitsb=3), then symbol 6 (bitsa=1, bitsb=2).
  - Then IDLE: tx_active=0, bits=0, underrun=0.
- 6 symbols (24 bits) delivered during the preamble with no pops:
  - fifo_level saturates at 4; overflow=1.
  - The first 4 symbols are emitted in order.
- Push of the 4th bit coincident with a boundary while the FIFO is full:
  - Pop and push both succeed; level stays 4; overflow stays 0.
- rst asserted mid-DATA with 3 symbols buffered:
  - Next cycle all outputs are 0 and fifo_level=0.
  - enable held high restarts with the preamble.
- enable dropped, then re-asserted during DRAIN with 2 symbols left:
  - No preamble; DATA resumes and the remaining symbols are emitted contiguously.
